// File: rtl/spi_target_if.sv
// rtl/spi_target_if.sv - SPI pad signals plus rx/tx word handshakes for spi_target
interface spi_target_if #(
    parameter int WORD_WIDTH = 8
);
    logic                  spi_clk;
    logic                  spi_mosi;
    logic                  spi_cs;
    logic                  spi_miso;
    logic                  spi_miso_en;
    logic [WORD_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [WORD_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  rx_overrun;
    logic                  busy;

    modport slave (
        input  spi_clk, spi_mosi, spi_cs, tx_data, tx_valid, rx_ready,
        output spi_miso, spi_miso_en, tx_ready, rx_data, rx_valid, rx_overrun, busy
    );

    modport master (
        output spi_clk, spi_mosi, spi_cs, tx_data, tx_valid, rx_ready,
        input  spi_miso, spi_miso_en, tx_ready, rx_data, rx_valid, rx_overrun, busy
    );
endinterface

// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI target: pad oversampling, word shifter and rx/tx handshakes
// Define SPI_TARGET_MODE_SELECT_EN to add cpol/cphase inputs; otherwise fixed to mode 0.
module spi_target #(
    parameter int                    WORD_WIDTH = 8,
    parameter logic [WORD_WIDTH-1:0] FILL_WORD  = '1
) (
    input  logic        i_clk,
    input  logic        i_rst,
`ifdef SPI_TARGET_MODE_SELECT_EN
    input  logic        i_cpol,
    input  logic        i_cphase,
`endif
    spi_target_if.slave bus
);
    localparam int            CW       = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t r_state, w_state_next;

    logic                  r_sck_s1, r_sck_s2, r_sck_s3;
    logic                  r_mosi_s1, r_mosi_s2;
    logic                  r_cs_s1, r_cs_s2, r_cs_s3;
    logic [CW-1:0]         r_bit_cnt;
    logic [WORD_WIDTH-1:0] r_tx_shift, r_hold, r_rx_data;
    logic [WORD_WIDTH-2:0] r_rx_shift;
    logic                  r_tx_ready, r_rx_valid, r_rx_overrun;

    logic w_cpol, w_cphase;
    logic w_sck_now, w_sck_prev, w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
    logic w_sample, w_shift, w_cs_load, w_leave, w_word_done, w_tx_load, w_rx_accept;
    logic [WORD_WIDTH-1:0] w_tx_word, w_rx_word;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sck_s1  <= 1'b0; r_sck_s2  <= 1'b0; r_sck_s3 <= 1'b0;
            r_mosi_s1 <= 1'b0; r_mosi_s2 <= 1'b0;
            r_cs_s1   <= 1'b1; r_cs_s2   <= 1'b1; r_cs_s3  <= 1'b1;
        end else begin
            r_sck_s1  <= bus.spi_clk;  r_sck_s2  <= r_sck_s1;  r_sck_s3 <= r_sck_s2;
            r_mosi_s1 <= bus.spi_mosi; r_mosi_s2 <= r_mosi_s1;
            r_cs_s1   <= bus.spi_cs;   r_cs_s2   <= r_cs_s1;   r_cs_s3  <= r_cs_s2;
        end
    end

`ifdef SPI_TARGET_MODE_SELECT_EN
    logic r_cpol, r_cphase;

    // Mode is frozen for the whole transaction once chip select falls.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cpol   <= 1'b0;
            r_cphase <= 1'b0;
        end else if (r_state == IDLE) begin
            r_cpol   <= i_cpol;
            r_cphase <= i_cphase;
        end
    end
    assign w_cpol   = r_cpol;
    assign w_cphase = r_cphase;
`else
    assign w_cpol   = 1'b0;
    assign w_cphase = 1'b0;
`endif

    assign w_sck_now  = r_sck_s2 ^ w_cpol;
    assign w_sck_prev = r_sck_s3 ^ w_cpol;
    assign w_sck_rise = w_sck_now & ~w_sck_prev;
    assign w_sck_fall = ~w_sck_now & w_sck_prev;
    assign w_cs_fall  = r_cs_s3 & ~r_cs_s2;
    assign w_cs_rise  = ~r_cs_s3 & r_cs_s2;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // A chip-select edge masks any SCK edge detected in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_cs_load    = 1'b0;
        w_leave      = 1'b0;
        w_sample     = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = ACTIVE;
                    w_cs_load    = ~w_cphase;
                end
            end
            ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_next = IDLE;
                    w_leave      = 1'b1;
                end else begin
                    w_sample = w_cphase ? w_sck_fall : w_sck_rise;
                    w_shift  = w_cphase ? w_sck_rise : w_sck_fall;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_word_done = w_sample & (r_bit_cnt == LAST_BIT);
    assign w_rx_accept = w_word_done & (~r_rx_valid | bus.rx_ready);
    assign w_rx_word   = {r_rx_shift, r_mosi_s2};
    assign w_tx_load   = w_cs_load | (w_shift & (r_bit_cnt == '0));
    assign w_tx_word   = r_tx_ready ? FILL_WORD : r_hold;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_bit_cnt    <= '0;
            r_tx_shift   <= '0;
            r_rx_shift   <= '0;
            r_hold       <= '0;
            r_tx_ready   <= 1'b1;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_rx_overrun <= w_word_done & ~w_rx_accept;
            if (w_leave) begin
                r_bit_cnt  <= '0;
                r_tx_shift <= '0;
                r_rx_shift <= '0;
            end else begin
                if (w_tx_load)    r_tx_shift <= w_tx_word;
                else if (w_shift) r_tx_shift <= {r_tx_shift[WORD_WIDTH-2:0], 1'b0};
                if (w_sample) begin
                    r_rx_shift <= w_rx_word[WORD_WIDTH-2:0];
                    r_bit_cnt  <= w_word_done ? '0 : r_bit_cnt + 1'b1;
                end
            end
            if (w_rx_accept) begin
                r_rx_data  <= w_rx_word;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid & bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            // A shifter load empties the holding register, so it never races a new offer.
            if (w_tx_load & ~r_tx_ready) begin
                r_tx_ready <= 1'b1;
            end else if (bus.tx_valid & r_tx_ready) begin
                r_hold     <= bus.tx_data;
                r_tx_ready <= 1'b0;
            end
        end
    end

    assign bus.spi_miso    = r_tx_shift[WORD_WIDTH-1];
    assign bus.spi_miso_en = (r_state == ACTIVE);
    assign bus.busy        = (r_state == ACTIVE);
    assign bus.tx_ready    = r_tx_ready;
    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.rx_overrun  = r_rx_overrun;
endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - self-checking bench for spi_target driving a mode-0 SPI controller
module tb_spi_target;
    localparam int           W    = 8;
    localparam logic [W-1:0] FILL = 8'hFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_target_if #(.WORD_WIDTH(W)) bus ();

    spi_target #(.WORD_WIDTH(W), .FILL_WORD(FILL)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
`ifdef SPI_TARGET_MODE_SELECT_EN
        .i_cpol   (1'b0),
        .i_cphase (1'b0),
`endif
        .bus      (bus)
    );

    int tests_run = 0;
    int fails     = 0;
    int cyc = 0, last_rise_cyc = 0, rise_cyc = -1, ovr_cnt = 0, vrise_cnt = 0;
    int half = 4;
    logic prev_v = 1'b0;
    logic [W-1:0] got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
            if (bus.rx_overrun) ovr_cnt++;
            if (bus.rx_valid && !prev_v) begin rise_cyc = cyc; vrise_cnt++; end
        end
        prev_v = bus.rx_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic offer_tx(input logic [W-1:0] w);
        int n = 0;
        @(negedge clk);
        while (bus.tx_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        tests_run++;
        if (n >= 50) begin fails++; $display("FAIL offer_wait: tx_ready never 1"); end
        bus.tx_data = w; bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic cs_low();
        @(negedge clk); bus.spi_cs = 1'b0;
        repeat (half) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (half) @(negedge clk); bus.spi_cs = 1'b1;
        repeat (half) @(negedge clk);
    endtask

    // Shifts nbits of mosi_w MSB first; MISO is captured on each SCK rise like a real controller.
    task automatic spi_xfer(input logic [W-1:0] mosi_w, input int nbits, input bit offer_en,
                            input logic [W-1:0] offer_w, output logic [W-1:0] miso_w);
        miso_w = '0;
        for (int b = W - 1; b >= W - nbits; b--) begin
            bus.spi_mosi = mosi_w[b];
            repeat (half) @(negedge clk);
            bus.spi_clk = 1'b1; miso_w[b] = bus.spi_miso; last_rise_cyc = cyc;
            if (offer_en && b == W - 1) begin
                tests_run++;
                if (bus.tx_ready !== 1'b1) begin
                    fails++; $display("FAIL midword_tx_ready: got %b expected 1", bus.tx_ready);
                end
                bus.tx_data = offer_w; bus.tx_valid = 1'b1;
                @(negedge clk); bus.tx_valid = 1'b0;
                repeat (half - 1) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
            bus.spi_clk = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.spi_clk = 1'b0; bus.spi_mosi = 1'b0; bus.spi_cs = 1'b1;
        bus.tx_data = '0; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        tests_run += 7;
        if (bus.spi_miso !== 1'b0)    begin fails++; $display("FAIL rst_miso: got %b expected 0", bus.spi_miso); end
        if (bus.spi_miso_en !== 1'b0) begin fails++; $display("FAIL rst_miso_en: got %b expected 0", bus.spi_miso_en); end
        if (bus.tx_ready !== 1'b1)    begin fails++; $display("FAIL rst_tx_ready: got %b expected 1", bus.tx_ready); end
        if (bus.rx_data !== '0)       begin fails++; $display("FAIL rst_rx_data: got %h expected 00", bus.rx_data); end
        if (bus.rx_valid !== 1'b0)    begin fails++; $display("FAIL rst_rx_valid: got %b expected 0", bus.rx_valid); end
        if (bus.rx_overrun !== 1'b0)  begin fails++; $display("FAIL rst_overrun: got %b expected 0", bus.rx_overrun); end
        if (bus.busy !== 1'b0)        begin fails++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_fill_word();
        logic [W-1:0] m, w;
        half = 4;
        bus.rx_ready = 1'b0;
        @(negedge clk); bus.spi_cs = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.spi_miso_en !== 1'b0) begin fails++; $display("FAIL cs_lat_early: got %b expected 0", bus.spi_miso_en); end
        @(negedge clk);
        tests_run += 3;
        if (bus.spi_miso_en !== 1'b1) begin fails++; $display("FAIL cs_lat_en: got %b expected 1", bus.spi_miso_en); end
        if (bus.busy !== 1'b1)        begin fails++; $display("FAIL cs_lat_busy: got %b expected 1", bus.busy); end
        if (bus.spi_miso !== FILL[W-1]) begin fails++; $display("FAIL cs_lat_miso: got %b expected %b", bus.spi_miso, FILL[W-1]); end
        repeat (half - 3) @(negedge clk);
        spi_xfer(8'hA5, W, 1'b0, '0, m);
        tests_run += 4;
        if (m !== FILL) begin fails++; $display("FAIL fill_miso: got %h expected %h", m, FILL); end
        if (rise_cyc - last_rise_cyc !== 3) begin fails++; $display("FAIL rx_latency: got %0d expected 3", rise_cyc - last_rise_cyc); end
        if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL rx_valid_set: got %b expected 1", bus.rx_valid); end
        if (bus.rx_data !== 8'hA5) begin fails++; $display("FAIL rx_data_a5: got %h expected a5", bus.rx_data); end
        bus.rx_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL rx_valid_clear: got %b expected 0", bus.rx_valid); end
        cs_high();
        for (int i = 0; i < 3; i++) begin
            got_q.delete();
            half = $urandom_range(4, 6);
            w = W'($urandom);
            cs_low();
            spi_xfer(w, W, 1'b0, '0, m);
            cs_high();
            tests_run += 2;
            if (m !== FILL) begin fails++; $display("FAIL rand_fill_miso: got %h expected %h", m, FILL); end
            if (got_q.size() != 1 || got_q[0] !== w) begin
                fails++; $display("FAIL rand_fill_rx: got %0d words first %h expected 1 word %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, w);
            end
        end
    endtask

    task automatic test_tx_load();
        logic [W-1:0] m, t, r;
        for (int i = 0; i < 4; i++) begin
            got_q.delete();
            half = (i == 0) ? 4 : $urandom_range(4, 6);
            t = (i == 0) ? 8'h3C : W'($urandom);
            r = (i == 0) ? 8'h00 : W'($urandom);
            offer_tx(t);
            tests_run++;
            if (bus.tx_ready !== 1'b0) begin fails++; $display("FAIL tx_ready_full: got %b expected 0", bus.tx_ready); end
            cs_low();
            tests_run++;
            if (bus.tx_ready !== 1'b1) begin fails++; $display("FAIL tx_ready_csfall: got %b expected 1", bus.tx_ready); end
            spi_xfer(r, W, 1'b0, '0, m);
            cs_high();
            tests_run += 2;
            if (m !== t) begin fails++; $display("FAIL tx_miso: got %h expected %h", m, t); end
            if (got_q.size() != 1 || got_q[0] !== r) begin
                fails++; $display("FAIL tx_rx_word: got %0d words expected 1 word %h", got_q.size(), r);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [W-1:0] mw[5], tw[5], m, exp_m;
        bit off[5];
        for (int it = 0; it < 4; it++) begin
            n = (it == 0) ? 2 : $urandom_range(2, 4);
            half = $urandom_range(4, 6);
            for (int i = 0; i < 5; i++) begin
                mw[i] = W'($urandom); tw[i] = W'($urandom); off[i] = bit'($urandom_range(0, 1));
            end
            if (it == 0) begin
                mw[0] = 8'h12; mw[1] = 8'h34; tw[0] = 8'h56; tw[1] = 8'h78; off[0] = 1; off[1] = 1;
            end
            got_q.delete();
            if (off[0]) offer_tx(tw[0]);
            cs_low();
            for (int i = 0; i < n; i++) begin
                spi_xfer(mw[i], W, (i + 1 < n) && off[i+1], tw[i+1], m);
                exp_m = off[i] ? tw[i] : FILL;
                tests_run++;
                if (m !== exp_m) begin fails++; $display("FAIL b2b_miso: word %0d got %h expected %h", i, m, exp_m); end
            end
            cs_high();
            tests_run++;
            if (got_q.size() != n) begin
                fails++; $display("FAIL b2b_rx_count: got %0d expected %0d", got_q.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    tests_run++;
                    if (got_q[i] !== mw[i]) begin fails++; $display("FAIL b2b_rx_word: word %0d got %h expected %h", i, got_q[i], mw[i]); end
                end
            end
        end
    endtask

    task automatic test_overrun();
        logic [W-1:0] m, w1, w2;
        half = $urandom_range(4, 6);
        w1 = W'($urandom); w2 = ~w1;
        @(negedge clk);
        bus.rx_ready = 1'b0; ovr_cnt = 0; got_q.delete();
        cs_low();
        spi_xfer(w1, W, 1'b0, '0, m);
        tests_run++;
        if (ovr_cnt !== 0) begin fails++; $display("FAIL ovr_early: got %0d expected 0", ovr_cnt); end
        spi_xfer(w2, W, 1'b0, '0, m);
        cs_high();
        tests_run += 3;
        if (ovr_cnt !== 1)         begin fails++; $display("FAIL ovr_pulse: got %0d cycles expected 1", ovr_cnt); end
        if (bus.rx_data !== w1)    begin fails++; $display("FAIL ovr_rx_data: got %h expected %h", bus.rx_data, w1); end
        if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL ovr_rx_valid: got %b expected 1", bus.rx_valid); end
        bus.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        tests_run += 2;
        if (got_q.size() != 1 || got_q[0] !== w1) begin fails++; $display("FAIL ovr_drain: got %0d words expected 1 word %h", got_q.size(), w1); end
        if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL ovr_valid_clear: got %b expected 0", bus.rx_valid); end
    endtask

    task automatic test_cs_abort();
        logic [W-1:0] m;
        int v0;
        half = 4;
        got_q.delete(); v0 = vrise_cnt;
        cs_low();
        spi_xfer(W'($urandom), 5, 1'b0, '0, m);
        repeat (half) @(negedge clk);
        bus.spi_cs = 1'b1;
        repeat (3) @(negedge clk);
        tests_run += 2;
        if (bus.spi_miso_en !== 1'b0) begin fails++; $display("FAIL abort_miso_en: got %b expected 0", bus.spi_miso_en); end
        if (bus.busy !== 1'b0)        begin fails++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        repeat (4) @(negedge clk);
        tests_run++;
        if (vrise_cnt !== v0 || got_q.size() != 0) begin fails++; $display("FAIL abort_no_rx: got %0d words expected 0", vrise_cnt - v0); end
        cs_low();
        spi_xfer(8'hC3, W, 1'b0, '0, m);
        cs_high();
        tests_run += 2;
        if (got_q.size() != 1 || got_q[0] !== 8'hC3) begin fails++; $display("FAIL abort_next_rx: got %0d words expected 1 word c3", got_q.size()); end
        if (m !== FILL) begin fails++; $display("FAIL abort_next_miso: got %h expected %h", m, FILL); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] m, w;
        half = 4;
        offer_tx(W'($urandom));
        cs_low();
        spi_xfer(W'($urandom), 3, 1'b1, W'($urandom), m);
        tests_run++;
        if (bus.tx_ready !== 1'b0) begin fails++; $display("FAIL rmid_pending: got %b expected 0", bus.tx_ready); end
        #3 rst = 1'b0;
        #1;
        tests_run += 7;
        if (bus.spi_miso !== 1'b0)    begin fails++; $display("FAIL rmid_miso: got %b expected 0", bus.spi_miso); end
        if (bus.spi_miso_en !== 1'b0) begin fails++; $display("FAIL rmid_miso_en: got %b expected 0", bus.spi_miso_en); end
        if (bus.tx_ready !== 1'b1)    begin fails++; $display("FAIL rmid_tx_ready: got %b expected 1", bus.tx_ready); end
        if (bus.rx_data !== '0)       begin fails++; $display("FAIL rmid_rx_data: got %h expected 00", bus.rx_data); end
        if (bus.rx_valid !== 1'b0)    begin fails++; $display("FAIL rmid_rx_valid: got %b expected 0", bus.rx_valid); end
        if (bus.rx_overrun !== 1'b0)  begin fails++; $display("FAIL rmid_overrun: got %b expected 0", bus.rx_overrun); end
        if (bus.busy !== 1'b0)        begin fails++; $display("FAIL rmid_busy: got %b expected 0", bus.busy); end
        bus.spi_cs = 1'b1; bus.spi_clk = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        got_q.delete();
        w = W'($urandom);
        cs_low();
        spi_xfer(w, W, 1'b0, '0, m);
        cs_high();
        tests_run += 2;
        if (m !== FILL) begin fails++; $display("FAIL rmid_hold_dropped: got %h expected %h", m, FILL); end
        if (got_q.size() != 1 || got_q[0] !== w) begin fails++; $display("FAIL rmid_rx: got %0d words expected 1 word %h", got_q.size(), w); end
    endtask

    initial begin
        test_reset();
        test_fill_word();
        test_tx_load();
        test_back_to_back();
        test_overrun();
        test_cs_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI target (responder) peripheral; the far end of the SPI0 controller pins (SPI0_CLK, SPI0_MOSI, SPI0_MISO, SPI0_CS) routed by the IO multiplexer.
- Lets an external or looped-back SPI controller exchange words with the SoC.
- Pad signals are oversampled in the system clock domain.
- Received words and words to transmit are passed to the core through valid/ready handshakes.

Parameters:
- WORD_WIDTH, 8: bits per SPI word, shifted MSB first.
- FILL_WORD, all ones: word shifted out when no tx word is pending.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- spi_clk  input  1  SCK from pad, asynchronous to clk.
- spi_mosi  input  1  controller-to-target data from pad.
- spi_cs  input  1  chip select from pad, active-low.
- spi_miso  output  1  target-to-controller data to pad.
- spi_miso_en  output  1  1 = drive MISO pad; 0 = release it (pad oeb = !spi_miso_en).
- tx_data  input  WORD_WIDTH  next word to transmit.
- tx_valid  input  1  tx_data offered.
- tx_ready  output  1  holding register empty.
- rx_data  output  WORD_WIDTH  last received word.
- rx_valid  output  1  rx_data valid; held until accepted.
- rx_ready  input  1  consumer accepts rx_data.
- rx_overrun  output  1  one-cycle pulse when a received word is dropped.
- busy  output  1  chip select active (synchronised).

Behaviour:
- Reset (rst=0, async): spi_miso=0, spi_miso_en=0, tx_ready=1, rx_data=0, rx_valid=0, rx_overrun=0, busy=0. Synchronisers reset to sck=0, mosi=0, cs=1. Bit counter and shift registers are cleared.
- Synchronisers: two flops per pad input, plus a third flop on sck and cs for edge detect. Required: SCK period >= 4 clk, SCK high and low each >= 2 clk.
- Mode 0 (CPOL=0, CPHA=0): sample MOSI on SCK rising; change MISO on SCK falling.
- States:
  - IDLE: synced cs=1. busy=0, spi_miso_en=0, bit counter held at 0.
  - IDLE -> ACTIVE on synced cs falling edge. Same cycle: load tx shift register from the holding register if tx_ready=0 (then tx_ready<=1), otherwise load FILL_WORD. spi_miso=MSB of the loaded word next cycle. spi_miso_en=1, busy=1.
  - ACTIVE, SCK rising: shift mosi into rx shift register LSB; bit counter increments.
  - ACTIVE, SCK rising when counter = WORD_WIDTH-1: word complete, counter wraps to 0.
    - If rx_valid=0 or rx_ready=1 that cycle: rx_data <= {rx_shift, mosi} and rx_valid <= 1.
    - Else: word dropped, rx_data unchanged, rx_overrun pulses 1 cycle.
  - ACTIVE, SCK falling with counter != 0: tx shift left, spi_miso = new MSB.
  - ACTIVE, SCK falling with counter = 0 (after a complete word): reload tx shift register (holding register or FILL_WORD, same rule as at CS fall) and present its MSB.
  - ACTIVE -> IDLE on synced cs rising edge. Partial rx word discarded, no rx_valid. Partial tx word lost; the holding register is not affected. Counter <= 0, spi_miso_en <= 0.
- rx handshake: rx_valid clears the cycle after rx_valid & rx_ready, unless a new word lands in that same cycle, in which case rx_valid stays 1 with the new data.
- tx handshake: the holding register loads on tx_valid & tx_ready, then tx_ready <= 0. If a shift-register load from the holding register coincides with tx_valid & tx_ready=0, the load takes the old word and the new offer is not accepted that cycle.
- Latency: rx_valid rises 3 clk after the pad SCK rising edge of the last bit. spi_miso updates 3 clk after the pad SCK falling edge or CS falling edge.
- SCK edges while synced cs=1 are ignored. An SCK edge and a CS edge detected in the same cycle: the CS edge wins.

Optional Feature:
- Macro SPI_TARGET_MODE_SELECT_EN.
- Defined: adds input ports cpol and cphase (1 bit each), sampled only in IDLE.
  - cpol inverts the synced SCK before edge detect.
  - cphase=1 shifts out on the leading edge and samples on the trailing edge; the first shift-out occurs on the first leading edge, not at CS fall.
- Undefined: the ports are absent and the block is fixed to mode 0 as above.

Test Plan:
- Reset, then CS low with no tx word, clock 8 bits of MOSI 0xA5 -> MISO 0xFF, rx_valid=1 with rx_data=0xA5 three clk after the 8th SCK rise; rx_ready=1 clears it the next cycle.
- tx_data=0x3C loaded before CS fall, controller sends 0x00 -> MISO bits 0,0,1,1,1,1,0,0 sampled on SCK rises; tx_ready returns to 1 at CS fall.
- Two back-to-back words 0x12, 0x34 under one CS with holding register reloaded (0x56, 0x78) -> MISO 0x56 then 0x78; rx_data sequence 0x12, 0x34.
- rx_ready held 0, two words received -> rx_data stays at first word, rx_overrun single-cycle pulse at second word completion.
- CS deasserted after 5 bits -> no rx_valid, spi_miso_en=0 within 3 clk; next transaction receives 0xC3 correctly from bit 0.
- rst asserted mid-word -> all outputs take reset values immediately, tx_ready=1, pending holding word discarded.
